// File: rtl/data_mem_access.sv
// Memory-side responder: turns the core's per-instruction memory op into a req/ack
// bus transaction, stalls the core, and returns extended load data. Optional: MEM_TIMEOUT_EN.
module data_mem_access #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        mem_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LB  = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;
    localparam logic [3:0] OP_SH  = 4'd8;

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("data_mem_access: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  alo_q, alo_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_err_q, mem_err_d;
    logic        bus_err_q, bus_err_d;

    logic        op_valid, op_store, misaligned, timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request decode from the live core inputs (only consumed in IDLE)
    always_comb begin
        op_valid   = (mem_op >= 4'd1) && (mem_op <= 4'd8);
        op_store   = (mem_op == OP_SW) || (mem_op == OP_SB) || (mem_op == OP_SH);
        misaligned = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = 32'h0;
        case (mem_op)
            OP_LW, OP_SW: begin
                misaligned = (addr[1:0] != 2'b00);
                be_calc    = 4'b1111;
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = addr[0];
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_LB, OP_LBU, OP_SB: begin
                be_calc = 4'b0001 << addr[1:0];
            end
            default: ;
        endcase
        case (mem_op)
            OP_SW:   wdata_calc = wdata;
            OP_SH:   wdata_calc = {2{wdata[15:0]}};
            OP_SB:   wdata_calc = {4{wdata[7:0]}};
            default: wdata_calc = 32'h0;
        endcase
    end

    // Load formatting uses the op and low address bits captured at issue
    always_comb begin
        case (alo_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = alo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q)
            OP_LW:   load_fmt = bus_rdata;
            OP_LB:   load_fmt = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_fmt = {24'h0, rd_byte};
            OP_LH:   load_fmt = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_fmt = {16'h0, rd_half};
            default: load_fmt = load_data_q;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // REQ is only ever entered from IDLE, so clearing there clears on entry
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ && !bus_ack) begin
            if (cnt_q == TIMEOUT_LIMIT) begin
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        alo_d       = alo_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        mem_err_d   = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = op_valid;
                if (op_valid) begin
                    if (misaligned) begin
                        state_d     = ST_DONE;
                        mem_err_d   = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        state_d     = ST_REQ;
                        op_d        = mem_op;
                        alo_d       = addr[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = op_store;
                        bus_addr_d  = addr[31:2];
                        bus_be_d    = be_calc;
                        bus_wdata_d = wdata_calc;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d = load_fmt;
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    load_data_d = 32'h0;
                    bus_err_d   = 1'b1;
                end
            end
            // The core still presents the completing op here; it must not reissue
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'd0;
            alo_q       <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 30'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
            mem_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            alo_q       <= alo_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            mem_err_q   <= mem_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign load_data = load_data_q;
    assign mem_err   = mem_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Memory-side responder for the core's memory-control interface.
- Consumes the per-instruction memory op code (NOP/LW/LB/LH/LBU/LHU/SW/SB/SH), effective address and store data.
- Runs a req/ack transaction on a 32-bit word-addressed data bus, stalling the core until completion.
- Returns byte/halfword/word load data with sign or zero extension, and flags misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 255: max REQ-state cycles without bus_ack before abort (used only with the optional feature).
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_op  in  4  op code: 0 NOP, 1 LW, 2 LB, 3 LH, 4 LBU, 5 LHU, 6 SW, 7 SB, 8 SH; 9-15 treated as NOP.
- addr  in  32  effective byte address from the ALU.
- wdata  in  32  store data from rt.
- stall  out  1  hold PC/register write while high.
- load_data  out  32  extended load result; valid in the cycle stall falls.
- mem_err  out  1  misaligned access, 1-cycle pulse.
- bus_err  out  1  bus timeout, 1-cycle pulse.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  30  word address (addr[31:2]).
- bus_be  out  4  byte enables; bit i = bits [8i+7:8i], little-endian.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  one-cycle completion from memory.
- bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, mem_err, bus_err.
  - Applies mid-transaction: bus_req drops immediately, no completion is reported.
- State machine:
  - IDLE:
    - stall = (mem_op valid, i.e. 1..8), combinational.
    - Valid and aligned: latch op, addr[1:0], bus_addr, bus_be, bus_wdata, bus_we; next state REQ, bus_req=1 from the next cycle.
    - Valid and misaligned: next state DONE with mem_err=1, load_data=0; no bus activity.
    - Misaligned means: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0.
  - REQ:
    - stall=1; bus_req held with all bus fields stable.
    - On bus_ack: drop bus_req, register formatted load_data (loads only), go DONE.
  - DONE:
    - stall=0 for exactly one cycle; mem_err/bus_err valid this cycle only.
    - Next state IDLE unconditionally.
    - mem_op is ignored here, since the core still presents the completing instruction; this prevents reissue.
- Write lanes:
  - SW: be=1111, wdata as-is.
  - SH: be=0011 if addr[1]=0 else 1100; wdata={2{wdata[15:0]}}.
  - SB: be=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
- Read lanes:
  - LW: be=1111.
  - LH/LHU: halfword selected by addr[1].
  - LB/LBU: byte selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store completion leaves load_data unchanged.
- bus_ack in IDLE or DONE is ignored; no error is raised.
- Latency, aligned op with ack k cycles after bus_req rises (k>=0): stall high for k+2 cycles, then one DONE cycle low.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop bus_req, set load_data=0, pulse bus_err in DONE.
  - If ack and the limit coincide, ack wins.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
- LW addr=0x0000_0010, bus_rdata=0xDEAD_BEEF, ack 2 cycles after req -> bus_addr=0x4, be=1111, stall high 4 cycles, load_data=0xDEAD_BEEF in DONE.
- LB addr=0x13, rdata=0x80FF_1234 -> be=1000, load_data=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr=0x12 -> 0xFFFF_80FF; LHU -> 0x0000_80FF.
- SB addr=0x21, wdata=0x1234_56AB -> bus_we=1, be=0010, bus_wdata=0xABAB_ABAB; SH addr=0x22, wdata=0x0000_CAFE -> be=1100, bus_wdata=0xCAFE_CAFE; load_data unchanged.
- LW addr=0x2 / SH addr=0x5 -> no bus_req, mem_err one cycle, stall high 1 cycle, load_data=0.
- rst_n low while in REQ -> bus_req=0 and state IDLE at once; a late bus_ack after reset is ignored, no DONE cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 REQ cycles, bus_err pulses, load_data=0; without macro stall remains high.
